// File: rtl/controlador_juego.sv
// Game sequencer: moves the obstacle once per frame and tracks lives and score.
// It runs the IDLE/PLAY/CRASH/OVER flow. Define SPEEDUP_EN to make the obstacle speed grow with the score.
module controlador_juego #(
   parameter int OBST_STEP    = 4,
   parameter int OBST_Y_START = 0,
   parameter int OBST_Y_END   = 479,
   parameter int LANE_L       = 160,
   parameter int LANE_R       = 480,
   parameter int LIVES        = 3,
   parameter int CRASH_FRAMES = 60,
   parameter int SCORE_W      = 10
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iFrameTick,
   input  logic               iStart,
   input  logic               iStop,
   output logic [9:0]         oPosicionXT,
   output logic [8:0]         oPosicionYT,
   output logic               oPlaying,
   output logic               oCrash,
   output logic               oGameOver,
   output logic [1:0]         oLives,
   output logic [SCORE_W-1:0] oScore
);

   localparam int CNT_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

   typedef enum logic [1:0] {IDLE, PLAY, CRASH, OVER} estadoT;

   estadoT             estado, estadoNext;
   logic [9:0]         posXNext;
   logic [8:0]         posYNext;
   logic [1:0]         livesNext;
   logic [SCORE_W-1:0] scoreNext;
   logic [CNT_W-1:0]   crashCnt, crashCntNext;
   logic               startQ;
   logic               startEvent;
   logic [9:0]         step;
   logic [9:0]         ySum;

`ifdef SPEEDUP_EN
   logic [SCORE_W-1:0] bonus;

   // One extra pixel per frame for every 8 points, capped at double speed.
   always_comb begin
      bonus = oScore >> 3;
      if (bonus > SCORE_W'(OBST_STEP))
         step = 10'(2 * OBST_STEP);
      else
         step = 10'(OBST_STEP) + 10'(bonus);
   end
`else
   assign step = 10'(OBST_STEP);
`endif

   // The sum is one bit wider than Y so that the wrap compare cannot overflow.
   assign ySum       = {1'b0, oPosicionYT} + step;
   assign startEvent = iStart & ~startQ;

   always_comb begin
      estadoNext   = estado;
      posXNext     = oPosicionXT;
      posYNext     = oPosicionYT;
      livesNext    = oLives;
      scoreNext    = oScore;
      crashCntNext = crashCnt;

      case (estado)
         IDLE, OVER: begin
            if (startEvent) begin
               estadoNext   = PLAY;
               posXNext     = 10'(LANE_L);
               posYNext     = 9'(OBST_Y_START);
               livesNext    = 2'(LIVES);
               scoreNext    = '0;
               crashCntNext = '0;
            end
         end
         PLAY: begin
            // A collision wins over a wrap, so a colliding tick never scores.
            if (iFrameTick) begin
               if (iStop) begin
                  estadoNext   = CRASH;
                  livesNext    = oLives - 2'd1;
                  crashCntNext = '0;
               end else if (ySum > 10'(OBST_Y_END)) begin
                  posYNext = 9'(OBST_Y_START);
                  posXNext = (oPosicionXT == 10'(LANE_L)) ? 10'(LANE_R) : 10'(LANE_L);
                  if (oScore != '1)
                     scoreNext = oScore + 1'b1;
               end else begin
                  posYNext = ySum[8:0];
               end
            end
         end
         CRASH: begin
            if (iFrameTick) begin
               if (crashCnt == CNT_W'(CRASH_FRAMES - 1)) begin
                  crashCntNext = '0;
                  if (oLives == 2'd0) begin
                     estadoNext = OVER;
                  end else begin
                     estadoNext = PLAY;
                     posYNext   = 9'(OBST_Y_START);
                  end
               end else begin
                  crashCntNext = crashCnt + 1'b1;
               end
            end
         end
         default: estadoNext = IDLE;
      endcase
   end

   // Status flags are decoded from the next state so that they line up with the state register.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         estado      <= IDLE;
         oPosicionXT <= 10'(LANE_L);
         oPosicionYT <= 9'(OBST_Y_START);
         oLives      <= 2'(LIVES);
         oScore      <= '0;
         crashCnt    <= '0;
         startQ      <= 1'b0;
         oPlaying    <= 1'b0;
         oCrash      <= 1'b0;
         oGameOver   <= 1'b0;
      end else begin
         estado      <= estadoNext;
         oPosicionXT <= posXNext;
         oPosicionYT <= posYNext;
         oLives      <= livesNext;
         oScore      <= scoreNext;
         crashCnt    <= crashCntNext;
         startQ      <= iStart;
         oPlaying    <= (estadoNext == PLAY);
         oCrash      <= (estadoNext == CRASH);
         oGameOver   <= (estadoNext == OVER);
      end
   end

endmodule

// File: tb/tb_controlador_juego.sv
// Testbench for controlador_juego: a game-rule model is checked against the DUT every cycle.
// Directed checks with hand-computed literal values confirm that the model itself is right.
module tb_controlador_juego;

   localparam int Y_END        = 479;
   localparam int CRASH_FRAMES = 60;
   localparam int SCORE_MAX    = 1023;
   localparam int M_IDLE = 0, M_PLAY = 1, M_CRASH = 2, M_OVER = 3;

   logic       iClk = 1'b0;
   logic       iRst_n, iFrameTick, iStart, iStop;
   logic [9:0] oPosicionXT;
   logic [8:0] oPosicionYT;
   logic       oPlaying, oCrash, oGameOver;
   logic [1:0] oLives;
   logic [9:0] oScore;

   int  testsRun = 0;
   int  testsFailed = 0;
   bit  checkEn = 1'b0;
   int  mMode, mY, mX, mLives, mScore, mCrashTicks;
   bit  mStartPrev;

   controlador_juego dut (
      .iClk(iClk), .iRst_n(iRst_n), .iFrameTick(iFrameTick), .iStart(iStart), .iStop(iStop),
      .oPosicionXT(oPosicionXT), .oPosicionYT(oPosicionYT), .oPlaying(oPlaying),
      .oCrash(oCrash), .oGameOver(oGameOver), .oLives(oLives), .oScore(oScore)
   );

   always #5 iClk = ~iClk;

   function automatic int stepFor(input int score);
`ifdef SPEEDUP_EN
      return 4 + (((score / 8) < 4) ? (score / 8) : 4);
`else
      return 4 + 0 * score;
`endif
   endfunction

   task automatic newGame();
      mMode       = M_PLAY;
      mY          = 0;
      mX          = 160;
      mLives      = 3;
      mScore      = 0;
      mCrashTicks = 0;
   endtask

   // Game rules as seen by the player, applied on every rising edge.
   task automatic modelStep();
      bit startEv;
      if (!iRst_n) begin
         newGame();
         mMode      = M_IDLE;
         mStartPrev = 1'b0;
      end else begin
         startEv = iStart && !mStartPrev;
         case (mMode)
            M_IDLE, M_OVER: if (startEv) newGame();
            M_PLAY: if (iFrameTick) begin
               if (iStop) begin
                  mMode       = M_CRASH;
                  mLives      = mLives - 1;
                  mCrashTicks = 0;
               end else if (mY + stepFor(mScore) > Y_END) begin
                  mY = 0;
                  mX = (mX == 160) ? 480 : 160;
                  if (mScore < SCORE_MAX) mScore = mScore + 1;
               end else begin
                  mY = mY + stepFor(mScore);
               end
            end
            M_CRASH: if (iFrameTick) begin
               mCrashTicks = mCrashTicks + 1;
               if (mCrashTicks == CRASH_FRAMES) begin
                  if (mLives == 0) begin
                     mMode = M_OVER;
                  end else begin
                     mMode = M_PLAY;
                     mY    = 0;
                  end
               end
            end
            default: mMode = M_IDLE;
         endcase
         mStartPrev = iStart;
      end
   endtask

   always @(posedge iClk) modelStep();

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun = testsRun + 1;
      if (act != exp) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge iClk) begin
      if (checkEn) begin
         checkOutput("modelPosY", int'(oPosicionYT), mY);
         checkOutput("modelPosX", int'(oPosicionXT), mX);
         checkOutput("modelLives", int'(oLives), mLives);
         checkOutput("modelScore", int'(oScore), mScore);
         checkOutput("modelPlaying", int'(oPlaying), int'(mMode == M_PLAY));
         checkOutput("modelCrash", int'(oCrash), int'(mMode == M_CRASH));
         checkOutput("modelGameOver", int'(oGameOver), int'(mMode == M_OVER));
      end
   end

   task automatic applyStimulus(input logic tick, input logic start, input logic stop);
      iFrameTick = tick;
      iStart     = start;
      iStop      = stop;
      @(negedge iClk);
   endtask

   task automatic runTicks(input int n, input logic start, input logic stop);
      repeat (n) begin
         applyStimulus(1'b1, start, stop);
         applyStimulus(1'b0, start, 1'b0);
      end
   endtask

   initial begin
      iRst_n = 1'b0;
      iFrameTick = 1'b0;
      iStart = 1'b0;
      iStop = 1'b0;
      @(negedge iClk);
      applyStimulus(0, 0, 0);
      checkEn = 1'b1;
      applyStimulus(0, 0, 0);
      checkOutput("resetPosY", int'(oPosicionYT), 0);
      checkOutput("resetPosX", int'(oPosicionXT), 160);
      checkOutput("resetLives", int'(oLives), 3);
      checkOutput("resetScore", int'(oScore), 0);
      checkOutput("resetFlags", int'({oPlaying, oCrash, oGameOver}), 0);

      iRst_n = 1'b1;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("startPlaying", int'(oPlaying), 1);
      runTicks(10, 0, 0);
      checkOutput("tenTicksY", int'(oPosicionYT), 40);
      runTicks(5, 1, 0);
      checkOutput("heldStartY", int'(oPosicionYT), 60);
      checkOutput("heldStartPlaying", int'(oPlaying), 1);

      runTicks(104, 0, 0);
      checkOutput("preWrapY", int'(oPosicionYT), 476);
      runTicks(1, 0, 0);
      checkOutput("wrapY", int'(oPosicionYT), 0);
      checkOutput("wrapX", int'(oPosicionXT), 480);
      checkOutput("wrapScore", int'(oScore), 1);
      runTicks(120, 0, 0);
      checkOutput("wrap2X", int'(oPosicionXT), 160);
      checkOutput("wrap2Score", int'(oScore), 2);

      // A collision flag between ticks must be ignored.
      repeat (3) applyStimulus(0, 0, 1);
      runTicks(1, 0, 0);
      checkOutput("stopBetweenTicks", int'(oCrash), 0);
      checkOutput("stopBetweenTicksY", int'(oPosicionYT), 4);
      runTicks(1, 0, 1);
      checkOutput("crashFlag", int'(oCrash), 1);
      checkOutput("crashLives", int'(oLives), 2);
      checkOutput("crashFrozenY", int'(oPosicionYT), 4);
      runTicks(59, 0, 0);
      checkOutput("crashStillAt59", int'(oCrash), 1);
      runTicks(1, 0, 0);
      checkOutput("crashResumePlaying", int'(oPlaying), 1);
      checkOutput("crashResumeY", int'(oPosicionYT), 0);
      checkOutput("crashKeepsScore", int'(oScore), 2);

      runTicks(1, 0, 1);
      runTicks(60, 0, 0);
      checkOutput("secondCrashLives", int'(oLives), 1);
      runTicks(1, 0, 1);
      runTicks(60, 0, 0);
      checkOutput("gameOverFlag", int'(oGameOver), 1);
      checkOutput("gameOverLives", int'(oLives), 0);
      runTicks(3, 0, 0);
      checkOutput("gameOverHoldsY", int'(oPosicionYT), 0);
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("restartPlaying", int'(oPlaying), 1);
      checkOutput("restartLives", int'(oLives), 3);
      checkOutput("restartScore", int'(oScore), 0);

      runTicks(119, 0, 0);
      runTicks(1, 0, 1);
      checkOutput("stopBeatsWrapCrash", int'(oCrash), 1);
      checkOutput("stopBeatsWrapScore", int'(oScore), 0);
      checkOutput("stopBeatsWrapY", int'(oPosicionYT), 476);

      iRst_n = 1'b0;
      applyStimulus(0, 0, 0);
      iRst_n = 1'b1;
      checkOutput("midGameResetY", int'(oPosicionYT), 0);
      checkOutput("midGameResetCrash", int'(oCrash), 0);
      checkOutput("midGameResetLives", int'(oLives), 3);

      // A frame tick that coincides with the start event must not move the obstacle.
      applyStimulus(1, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("startWithTickPlaying", int'(oPlaying), 1);
      checkOutput("startWithTickY", int'(oPosicionYT), 0);

`ifdef SPEEDUP_EN
      runTicks(960, 0, 0);
      checkOutput("speedupScore", int'(oScore), 8);
      runTicks(1, 0, 0);
      checkOutput("speedupStep5", int'(oPosicionYT), 5);
`endif

      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
